// File: rtl/uart_arb_pkg.sv
// Shared constants for the uart_tx arbiter: FSM encoding and default sizing.
package uart_arb_pkg;

  localparam int N_REQ_DEF = 2;
  localparam int ID_W_DEF  = 3;

  localparam logic [1:0] ST_ARB       = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector; a held lock restricts the grant to the locked index.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = ID_W_DEF
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  input  logic             lock_en_i,
  input  logic [ID_W-1:0]  lock_id_i,
  output logic             grant_valid_o,
  output logic [ID_W-1:0]  grant_id_o
);

  always_comb begin
    grant_valid_o = 1'b0;
    grant_id_o    = '0;
    if (lock_en_i) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_i[i] && (ID_W'(i) == lock_id_i)) begin
          grant_valid_o = 1'b1;
          grant_id_o    = ID_W'(i);
        end
      end
    end else begin
      // Farthest offset first so the requester nearest the pointer overwrites last.
      for (int n = N_REQ - 1; n >= 0; n--) begin
        for (int i = 0; i < N_REQ; i++) begin
          if (req_i[i] && (i == ((int'(ptr_i) + n) % N_REQ))) begin
            grant_valid_o = 1'b1;
            grant_id_o    = ID_W'(i);
          end
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte producers,
// with a per-message lock so Last-terminated messages are never interleaved.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = ID_W_DEF
) (
  input  logic               i_Clock,
  input  logic               i_Rst_n,
  input  logic [N_REQ-1:0]   i_Req_Valid,
  input  logic [8*N_REQ-1:0] i_Req_Byte,
  input  logic [N_REQ-1:0]   i_Req_Last,
  output logic [N_REQ-1:0]   o_Req_Ready,
  output logic               o_Tx_DV,
  output logic [7:0]         o_Tx_Byte,
  input  logic               i_Tx_Active,
  input  logic               i_Tx_Done,
  output logic               o_Busy,
  output logic [ID_W-1:0]    o_Grant_Id,
  output logic [15:0]        o_Byte_Count
);

  logic [1:0]      state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            lock_q, lock_d;
  logic [ID_W-1:0] lock_id_q, lock_id_d;
  logic            last_q, last_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic            tx_dv_q, tx_dv_d;
  logic [15:0]     byte_cnt_q, byte_cnt_d;

  logic            pick_valid;
  logic [ID_W-1:0] pick_id;
  logic            grant_go;
  logic [7:0]      sel_byte;
  logic            sel_last;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req_i         (i_Req_Valid),
    .ptr_i         (ptr_q),
    .lock_en_i     (lock_q),
    .lock_id_i     (lock_id_q),
    .grant_valid_o (pick_valid),
    .grant_id_o    (pick_id)
  );

  // Active or Done high means uart_tx is mid-frame or in CLEANUP; DV would be lost or doubled.
  assign grant_go = i_Rst_n && (state_q == ST_ARB) && !i_Tx_Active && !i_Tx_Done && pick_valid;

  always_comb begin
    sel_byte    = '0;
    sel_last    = 1'b0;
    o_Req_Ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == pick_id) begin
        sel_byte       = i_Req_Byte[8*i +: 8];
        sel_last       = i_Req_Last[i];
        o_Req_Ready[i] = grant_go;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    lock_id_d  = lock_id_q;
    last_d     = last_q;
    tx_byte_d  = tx_byte_q;
    grant_id_d = grant_id_q;
    tx_dv_d    = tx_dv_q;
    byte_cnt_d = byte_cnt_q;
    case (state_q)
      ST_ARB: begin
        if (grant_go) begin
          tx_byte_d  = sel_byte;
          grant_id_d = pick_id;
          last_d     = sel_last;
          tx_dv_d    = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (i_Tx_Active) begin
          tx_dv_d    = 1'b0;
          byte_cnt_d = byte_cnt_q + 16'd1;
          state_d    = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (i_Tx_Done) begin
          state_d = ST_ARB;
          if (last_q) begin
            lock_d = 1'b0;
            ptr_d  = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
          end else begin
            lock_d    = 1'b1;
            lock_id_d = grant_id_q;
          end
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= ST_ARB;
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_id_q  <= '0;
      last_q     <= 1'b0;
      tx_byte_q  <= '0;
      grant_id_q <= '0;
      tx_dv_q    <= 1'b0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_id_q  <= lock_id_d;
      last_q     <= last_d;
      tx_byte_q  <= tx_byte_d;
      grant_id_q <= grant_id_d;
      tx_dv_q    <= tx_dv_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign o_Tx_DV      = tx_dv_q;
  assign o_Tx_Byte    = tx_byte_q;
  assign o_Grant_Id   = grant_id_q;
  assign o_Byte_Count = byte_cnt_q;
  assign o_Busy       = (state_q != ST_ARB) | lock_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter with a uart_tx model, a serial receiver
// and a transaction-level round-robin/lock reference model.
module tb_uart_tx_arbiter;

  localparam int N   = 2;
  localparam int IDW = 3;
  localparam int CPB = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_byte;
  logic [N-1:0]   req_last;
  logic [N-1:0]   o_Req_Ready;
  logic           o_Tx_DV;
  logic [7:0]     o_Tx_Byte;
  logic           o_Busy;
  logic [IDW-1:0] o_Grant_Id;
  logic [15:0]    o_Byte_Count;

  logic       tx_line = 1'b1, tx_active = 1'b0, tx_done = 1'b0;
  int         us = 0, ucnt = 0, uidx = 0;
  logic [7:0] ush = 8'h00;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .ID_W(IDW)) dut (
    .i_Clock      (clk),
    .i_Rst_n      (rst_n),
    .i_Req_Valid  (req_valid),
    .i_Req_Byte   (req_byte),
    .i_Req_Last   (req_last),
    .o_Req_Ready  (o_Req_Ready),
    .o_Tx_DV      (o_Tx_DV),
    .o_Tx_Byte    (o_Tx_Byte),
    .i_Tx_Active  (tx_active),
    .i_Tx_Done    (tx_done),
    .o_Busy       (o_Busy),
    .o_Grant_Id   (o_Grant_Id),
    .o_Byte_Count (o_Byte_Count)
  );

  // uart_tx model (no reset): IDLE, START, DATA, STOP, CLEANUP; Done high in CLEANUP and first IDLE cycle.
  always @(posedge clk) begin
    case (us)
      0: begin
        tx_line <= 1'b1; tx_done <= 1'b0; ucnt <= 0; uidx <= 0;
        if (o_Tx_DV) begin tx_active <= 1'b1; ush <= o_Tx_Byte; us <= 1; end
        else tx_active <= 1'b0;
      end
      1: begin
        tx_line <= 1'b0;
        if (ucnt < CPB - 1) ucnt <= ucnt + 1; else begin ucnt <= 0; us <= 2; end
      end
      2: begin
        tx_line <= ush[uidx];
        if (ucnt < CPB - 1) ucnt <= ucnt + 1;
        else begin
          ucnt <= 0;
          if (uidx < 7) uidx <= uidx + 1; else begin uidx <= 0; us <= 3; end
        end
      end
      3: begin
        tx_line <= 1'b1;
        if (ucnt < CPB - 1) ucnt <= ucnt + 1;
        else begin ucnt <= 0; tx_done <= 1'b1; tx_active <= 1'b0; us <= 4; end
      end
      default: begin tx_done <= 1'b1; us <= 0; end
    endcase
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  logic [8:0] pq [N][1024];
  int         ph [N];
  int         pt [N];
  bit         hold [N];
  int         vprob = 100;
  int         rdy_cnt [N];

  logic [7:0] gbyte [4096];
  int         gid [4096];
  int         g_n = 0;
  logic [7:0] rxb [4096];
  int         rx_n = 0;
  logic [9:0] rx_fr;
  logic [9:0] last_frame;

  int ptr_m = 0;
  bit lock_m = 1'b0;
  int lock_id_m = 0;

  logic [N-1:0] hs;
  logic dv_prev = 1'b0, act_prev = 1'b0, done_prev = 1'b0;
  int   mk, mek;

  task automatic push(input int k, input logic [7:0] b, input logic l);
    pq[k][pt[k]] = {l, b};
    pt[k]++;
  endtask

  function automatic bit queues_empty();
    for (int k = 0; k < N; k++) if (ph[k] != pt[k]) return 1'b0;
    return 1'b1;
  endfunction

  // Reference arbitration rule: locked index only, else first valid from the pointer upward.
  function automatic int exp_pick();
    if (lock_m) return req_valid[lock_id_m] ? lock_id_m : -1;
    for (int n = 0; n < N; n++) begin
      int j;
      j = (ptr_m + n) % N;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  initial begin : drive_mon
    req_valid = '0;
    req_byte  = '0;
    req_last  = '0;
    for (int k = 0; k < N; k++) begin ph[k] = 0; pt[k] = 0; hold[k] = 1'b0; rdy_cnt[k] = 0; end
    forever begin
      @(negedge clk);
      hs = '0;
      if (o_Req_Ready != '0) begin
        check_eq("rdy_onehot", 32'($onehot(o_Req_Ready)), 32'd1);
        check_eq("rdy_idle", {29'd0, tx_active, tx_done, o_Tx_DV}, 32'd0);
        mk = 0;
        for (int i = 0; i < N; i++) if (o_Req_Ready[i]) mk = i;
        mek = exp_pick();
        check_eq("grant_order", mk, mek);
        hs[mk] = 1'b1;
        rdy_cnt[mk]++;
        gbyte[g_n] = pq[mk][ph[mk]][7:0];
        gid[g_n] = mk;
        g_n++;
        if (pq[mk][ph[mk]][8]) begin ptr_m = (mk + 1) % N; lock_m = 1'b0; end
        else begin lock_m = 1'b1; lock_id_m = mk; end
      end
      if (o_Tx_DV && !dv_prev && g_n > 0) begin
        check_eq("dv_after_done", {30'd0, act_prev, done_prev}, 32'd0);
        check_eq("tx_byte", o_Tx_Byte, gbyte[g_n-1]);
        check_eq("grant_id", o_Grant_Id, gid[g_n-1]);
      end
      dv_prev = o_Tx_DV; act_prev = tx_active; done_prev = tx_done;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) if (hs[k]) ph[k]++;
      for (int k = 0; k < N; k++) begin
        if (ph[k] < pt[k]) begin
          req_valid[k] = !hold[k] && ($urandom_range(99) < vprob);
          req_byte[8*k +: 8] = pq[k][ph[k]][7:0];
          req_last[k] = pq[k][ph[k]][8];
        end else begin
          req_valid[k] = 1'b0;
          req_byte[8*k +: 8] = 8'h00;
          req_last[k] = 1'b0;
        end
      end
    end
  end

  initial begin : rx_proc
    forever begin
      @(negedge clk);
      if (tx_line === 1'b0) begin
        rx_fr[0] = 1'b0;
        for (int j = 1; j < 10; j++) begin
          repeat (CPB) @(negedge clk);
          rx_fr[j] = tx_line;
        end
        last_frame = rx_fr;
        if (rx_n < g_n) check_eq("rx_byte", rx_fr[8:1], gbyte[rx_n]);
        else check_eq("rx_extra", rx_n, g_n);
        check_eq("rx_stop", rx_fr[9], 1);
        rxb[rx_n] = rx_fr[8:1];
        rx_n++;
      end
    end
  end

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (c < budget) begin
      @(negedge clk);
      if (queues_empty() && rx_n == g_n && !o_Busy && !tx_active && !tx_done && !o_Tx_DV) break;
      c++;
    end
    if (c >= budget) check_eq("idle_timeout", c, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ptr_m = 0; lock_m = 1'b0; lock_id_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_dv"}, o_Tx_DV, 0);
    check_eq({pfx, "_byte"}, o_Tx_Byte, 0);
    check_eq({pfx, "_ready"}, o_Req_Ready, 0);
    check_eq({pfx, "_busy"}, o_Busy, 0);
    check_eq({pfx, "_gid"}, o_Grant_Id, 0);
    check_eq({pfx, "_cnt"}, o_Byte_Count, 0);
  endtask

  int base, errs, len, c;

  initial begin : main
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    push(0, 8'hA5, 1'b1);
    wait_idle(2000);
    check_eq("basic_frame", last_frame, 10'b11_0100_1010);
    check_eq("basic_ready_pulses", rdy_cnt[0], 1);
    check_eq("basic_count", o_Byte_Count, 1);
    check_eq("basic_gid", o_Grant_Id, 0);

    do_reset();
    base = g_n;
    for (int i = 0; i < 6; i++) begin push(0, 8'(8'h10 + i), 1'b1); push(1, 8'(8'h20 + i), 1'b1); end
    wait_idle(4000);
    for (int i = 0; i < 12; i++) check_eq("fair_order", gid[base+i], i % 2);
    check_eq("fair_count", o_Byte_Count, 12);

    do_reset();
    base = rx_n;
    push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1); push(1, 8'h44, 1'b1);
    wait_idle(3000);
    check_eq("lock_b0", rxb[base], 8'h11);
    check_eq("lock_b1", rxb[base+1], 8'h22);
    check_eq("lock_b2", rxb[base+2], 8'h33);
    check_eq("lock_b3", rxb[base+3], 8'h44);

    do_reset();
    base = rx_n;
    push(0, 8'h11, 1'b0); push(1, 8'h55, 1'b1);
    c = 0;
    while (c < 1000 && !(rx_n == base + 1 && !tx_active && !tx_done)) begin @(negedge clk); c++; end
    if (c >= 1000) check_eq("stall_timeout", c, 0);
    errs = 0;
    repeat (50) begin
      @(negedge clk);
      if (o_Req_Ready != '0 || !o_Busy) errs++;
    end
    check_eq("stall_block", errs, 0);
    check_eq("stall_grants", g_n, base + 1);
    push(0, 8'h22, 1'b1);
    wait_idle(3000);
    check_eq("stall_b0", rxb[base], 8'h11);
    check_eq("stall_b1", rxb[base+1], 8'h22);
    check_eq("stall_b2", rxb[base+2], 8'h55);

    do_reset();
    base = rx_n;
    for (int i = 0; i < 256; i++) push(0, 8'(i), 1'b1);
    wait_idle(20000);
    check_eq("b2b_count", o_Byte_Count, 256);
    check_eq("b2b_rx_n", rx_n - base, 256);
    errs = 0;
    for (int i = 0; i < 256; i++) if (rxb[base+i] !== 8'(i)) errs++;
    check_eq("b2b_seq", errs, 0);

    do_reset();
    vprob = 60;
    base = g_n;
    for (int k = 0; k < N; k++) begin
      for (int m = 0; m < 8; m++) begin
        len = int'($urandom_range(4, 1));
        for (int b = 0; b < len; b++) push(k, 8'($urandom), b == len - 1);
      end
    end
    wait_idle(30000);
    check_eq("rand_count", o_Byte_Count, g_n - base);
    check_eq("rand_rx_n", rx_n, g_n);
    vprob = 100;

    do_reset();
    push(0, 8'hA1, 1'b1);
    wait_idle(2000);
    base = g_n;
    push(1, 8'h3C, 1'b1);
    c = 0;
    while (c < 1000 && !(us == 2 && uidx == 3)) begin @(negedge clk); c++; end
    if (c >= 1000) check_eq("midrst_timeout", c, 0);
    #2;
    rst_n = 1'b0;
    ptr_m = 0; lock_m = 1'b0; lock_id_m = 0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push(0, 8'h5A, 1'b1); push(1, 8'h6B, 1'b1);
    wait_idle(3000);
    check_eq("midrst_ptr", gid[base+1], 0);
    check_eq("midrst_b0", rxb[base], 8'h3C);
    check_eq("midrst_b1", rxb[base+1], 8'h5A);
    check_eq("midrst_b2", rxb[base+2], 8'h6B);
    check_eq("midrst_no_dup", rx_n, base + 3);
    check_eq("midrst_count", o_Byte_Count, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
